// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS-subset decode stage with bypassed register file,
// load-use hazard detection and the ID/EX pipeline latch.
module id_stage_hz #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [DW-1:0] id_npc,
    input  logic [31:0]   instrout,
    input  logic          regwrite,
    input  logic [AW-1:0] rd,
    input  logic [DW-1:0] writedata,
    input  logic          flush,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [1:0]    ex_ctlwb_out,
    output logic [2:0]    ex_ctlm_out,
    output logic [3:0]    ex_ctlout,
    output logic          ex_illegal,
    output logic [DW-1:0] add_in1,
    output logic [DW-1:0] A,
    output logic [DW-1:0] ex_readdat2,
    output logic [DW-1:0] s_extendout,
    output logic [5:0]    funct,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_b,
    output logic [AW-1:0] ex_a
);
    logic [DW-1:0] rf [NREG];
    logic [5:0]    op;
    logic [AW-1:0] rs, rt, rdf;
    logic [8:0]    ctl;
    logic          illegal, uses_rt, wr_en, load;
    logic [DW-1:0] rs_data, rt_data;

    assign op      = instrout[31:26];
    assign rs      = AW'(instrout[25:21]);
    assign rt      = AW'(instrout[20:16]);
    assign rdf     = AW'(instrout[15:11]);
    assign wr_en   = regwrite && rd != '0;
    // r0 is never written, so its reset value keeps it reading as zero
    assign rs_data = (wr_en && rd == rs) ? writedata : rf[rs];
    assign rt_data = (wr_en && rd == rt) ? writedata : rf[rt];

    assign ctl = op == 6'h00 ? 9'b10_000_1100 :
                 op == 6'h23 ? 9'b11_010_0001 :
                 op == 6'h2B ? 9'b00_001_0001 :
                 op == 6'h04 ? 9'b00_100_0010 : 9'b0;
    assign illegal = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04});
    assign uses_rt = op inside {6'h00, 6'h2B, 6'h04};

    // load in EX whose destination is a source of the decoding instruction
    assign id_stall = !reset && !flush && id_valid && ex_valid && ex_ctlm_out[1] && ex_b != '0 &&
                      (ex_b == rs || (ex_b == rt && uses_rt));
    assign load = id_valid && !flush && !id_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[rd] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_ctlwb_out <= '0;
            ex_ctlm_out  <= '0;
            ex_ctlout    <= '0;
            ex_illegal   <= 1'b0;
            add_in1      <= '0;
            A            <= '0;
            ex_readdat2  <= '0;
            s_extendout  <= '0;
            funct        <= '0;
            ex_rs        <= '0;
            ex_b         <= '0;
            ex_a         <= '0;
        end else begin
            ex_valid                                <= load;
            {ex_ctlwb_out, ex_ctlm_out, ex_ctlout} <= load ? ctl : 9'b0;
            ex_illegal                              <= load && illegal;
            add_in1                                 <= id_npc;
            A                                       <= rs_data;
            ex_readdat2                             <= rt_data;
            s_extendout                             <= DW'($signed(instrout[15:0]));
            funct                                   <= instrout[5:0];
            ex_rs                                   <= rs;
            ex_b                                    <= rt;
            ex_a                                    <= rdf;
        end
    end
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed and randomized checks of id_stage_hz against a
// behavioural model of register file, decode table, hazard rule and ID/EX latch.
module tb_id_stage_hz;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        id_valid, regwrite, flush;
    logic [31:0] id_npc, instrout, writedata;
    logic [4:0]  rd;
    logic        id_stall, ex_valid, ex_illegal;
    logic [1:0]  ex_ctlwb_out;
    logic [2:0]  ex_ctlm_out;
    logic [3:0]  ex_ctlout;
    logic [31:0] add_in1, A, ex_readdat2, s_extendout;
    logic [5:0]  funct;
    logic [4:0]  ex_rs, ex_b, ex_a;

    id_stage_hz u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_npc(id_npc), .instrout(instrout),
        .regwrite(regwrite), .rd(rd), .writedata(writedata), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctlwb_out(ex_ctlwb_out),
        .ex_ctlm_out(ex_ctlm_out), .ex_ctlout(ex_ctlout), .ex_illegal(ex_illegal),
        .add_in1(add_in1), .A(A), .ex_readdat2(ex_readdat2), .s_extendout(s_extendout),
        .funct(funct), .ex_rs(ex_rs), .ex_b(ex_b), .ex_a(ex_a)
    );

    logic        s_valid, s_rw, s_flush;
    logic [15:0] s_npc, s_wd;
    logic [31:0] s_instr;
    logic [2:0]  s_rd;
    logic        s_stall, s_exv, s_ill;
    logic [1:0]  s_wb;
    logic [2:0]  s_m;
    logic [3:0]  s_ex;
    logic [15:0] s_add, s_a, s_b, s_sx;
    logic [5:0]  s_fn;
    logic [2:0]  s_rs, s_rt, s_rdo;

    id_stage_hz #(.DW(16), .NREG(8)) u_small (
        .clk(clk), .reset(reset), .id_valid(s_valid), .id_npc(s_npc), .instrout(s_instr),
        .regwrite(s_rw), .rd(s_rd), .writedata(s_wd), .flush(s_flush),
        .id_stall(s_stall), .ex_valid(s_exv), .ex_ctlwb_out(s_wb), .ex_ctlm_out(s_m),
        .ex_ctlout(s_ex), .ex_illegal(s_ill), .add_in1(s_add), .A(s_a), .ex_readdat2(s_b),
        .s_extendout(s_sx), .funct(s_fn), .ex_rs(s_rs), .ex_b(s_rt), .ex_a(s_rdo)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference state: architectural registers and the expected EX-stage contents
    logic [31:0] mrf [32];
    logic        e_valid, e_ill;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic [31:0] e_npc, e_a, e_b, e_sx;
    logic [5:0]  e_fn;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic        dut_stall, exp_stall;

    function automatic logic [9:0] spec_ctl(input logic [5:0] op);
        case (op)
            6'h00:   return {9'b10_000_1100, 1'b0};
            6'h23:   return {9'b11_010_0001, 1'b0};
            6'h2B:   return {9'b00_001_0001, 1'b0};
            6'h04:   return {9'b00_100_0010, 1'b0};
            default: return {9'b0, 1'b1};
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'h0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        {e_valid, e_ill, e_wb, e_m, e_ex, e_npc, e_a, e_b, e_sx, e_fn, e_rs, e_rt, e_rd} = '0;
    endtask

    task automatic check_outputs();
        chk("valid", ex_valid, e_valid);
        chk("ctl", {ex_ctlwb_out, ex_ctlm_out, ex_ctlout, ex_illegal}, {e_wb, e_m, e_ex, e_ill});
        chk("npc", add_in1, e_npc);
        chk("rs_data", A, e_a);
        chk("rt_data", ex_readdat2, e_b);
        chk("sext", s_extendout, e_sx);
        chk("fields", {funct, ex_rs, ex_b, ex_a}, {e_fn, e_rs, e_rt, e_rd});
    endtask

    // one clock of the large DUT; called at posedge+1, returns at the next posedge+1
    task automatic cyc(input logic v, input logic [31:0] npc, ins, input logic rw,
                       input logic [4:0] wrd, input logic [31:0] wd, input logic fl);
        logic [4:0]  rs, rt;
        logic [5:0]  op;
        logic        uses_rt, ld;
        logic [9:0]  dc;
        logic [31:0] va, vb;
        {id_valid, id_npc, instrout, regwrite, rd, writedata, flush} = {v, npc, ins, rw, wrd, wd, fl};
        #1;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        uses_rt = (op == 6'h00 || op == 6'h2B || op == 6'h04);
        exp_stall = !fl && v && e_valid && e_m[1] && e_rt != 0 && (e_rt == rs || (e_rt == rt && uses_rt));
        dut_stall = id_stall;
        chk("stall", id_stall, exp_stall);
        ld = v && !fl && !exp_stall;
        dc = spec_ctl(op);
        va = (rw && wrd != 0 && wrd == rs) ? wd : mrf[rs];
        vb = (rw && wrd != 0 && wrd == rt) ? wd : mrf[rt];
        @(posedge clk);
        #1;
        if (rw && wrd != 0) mrf[wrd] = wd;
        e_valid = ld;
        {e_wb, e_m, e_ex} = ld ? dc[9:1] : 9'b0;
        e_ill = ld && dc[0];
        e_npc = npc;
        e_a = va;
        e_b = vb;
        e_sx = {{16{ins[15]}}, ins[15:0]};
        e_fn = ins[5:0];
        e_rs = rs;
        e_rt = rt;
        e_rd = ins[15:11];
        check_outputs();
    endtask

    initial begin
        {id_valid, id_npc, instrout, regwrite, rd, writedata, flush} = '0;
        {s_valid, s_npc, s_instr, s_rw, s_rd, s_wd, s_flush} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("stall_in_reset", id_stall, 1'b0);
        reset = 1'b0;

        // reset clears the register file: preload r5, reset, read it back
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234_5678, 1'b0);
        reset = 1'b1;
        #1;
        chk("async_reset_valid", ex_valid, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 32'h4, rtype(5'd5, 5'd0, 5'd1, 6'h20), 1'b0, 5'd0, 32'h0, 1'b0);
        chk("r5_after_reset", A, 32'h0);

        // same-cycle write-through
        cyc(1'b1, 32'h8, rtype(5'd7, 5'd7, 5'd1, 6'h20), 1'b1, 5'd7, 32'hDEAD, 1'b0);
        chk("bypass_a", A, 32'hDEAD);
        chk("bypass_b", ex_readdat2, 32'hDEAD);

        // load-use: one stall, one bubble, then the add passes
        cyc(1'b1, 32'hC, itype(6'h23, 5'd1, 5'd3, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 32'h10, rtype(5'd3, 5'd2, 5'd4, 6'h20), 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lu_stall", dut_stall, 1'b1);
        chk("lu_bubble", {ex_valid, ex_ctlwb_out, ex_ctlm_out, ex_ctlout}, 10'b0);
        cyc(1'b1, 32'h10, rtype(5'd3, 5'd2, 5'd4, 6'h20), 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lu_pass_stall", dut_stall, 1'b0);
        chk("lu_pass_wb", ex_ctlwb_out, 2'b10);

        // sw using the loaded base stalls; loads of r0 never do
        cyc(1'b1, 32'h14, itype(6'h23, 5'd1, 5'd3, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 32'h18, itype(6'h2B, 5'd3, 5'd0, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
        chk("sw_stall", dut_stall, 1'b1);
        cyc(1'b1, 32'h18, itype(6'h2B, 5'd3, 5'd0, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 32'h1C, itype(6'h23, 5'd1, 5'd0, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 32'h20, rtype(5'd0, 5'd0, 5'd4, 6'h20), 1'b0, 5'd0, 32'h0, 1'b0);
        chk("r0_no_stall", dut_stall, 1'b0);

        // flush overrides the hazard and latches a bubble
        cyc(1'b1, 32'h24, itype(6'h23, 5'd1, 5'd3, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 32'h28, rtype(5'd3, 5'd2, 5'd4, 6'h20), 1'b0, 5'd0, 32'h0, 1'b1);
        chk("flush_stall", dut_stall, 1'b0);
        chk("flush_bubble", ex_valid, 1'b0);

        // random traffic; IF/ID re-presents a stalled instruction
        begin
            logic        v, rw, fl;
            logic [31:0] npc, ins, wd;
            logic [4:0]  wrd;
            v = 1'b0;
            npc = 32'h100;
            ins = '0;
            for (int i = 0; i < 1500; i++) begin
                if (!dut_stall) begin
                    int k;
                    logic [5:0] op;
                    logic [4:0] s, t;
                    k = $urandom_range(0, 9);
                    op = k < 3 ? 6'h00 : (k < 5 || k == 9) ? 6'h23 : k < 7 ? 6'h2B : k == 7 ? 6'h04 :
                         ($urandom_range(0, 1) ? 6'h3F : 6'h08);
                    s = 5'($urandom_range(0, 7));
                    t = 5'($urandom_range(0, 7));
                    ins = {op, s, t, 16'($urandom)};
                    v = $urandom_range(0, 9) != 0;
                    npc = npc + 32'd4;
                end
                rw = $urandom_range(0, 1) == 1;
                wrd = 5'($urandom_range(0, 7));
                wd = $urandom;
                fl = $urandom_range(0, 9) == 0;
                cyc(v, npc, ins, rw, wrd, wd, fl);
            end
        end

        // reset in the middle of a cycle drops the in-flight instruction at once
        cyc(1'b1, 32'h200, itype(6'h23, 5'd2, 5'd6, 16'h8000), 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", ex_valid, 1'b0);
        chk("mid_reset_ctl", {ex_ctlwb_out, ex_ctlm_out, ex_ctlout}, 9'b0);
        chk("mid_reset_sext", s_extendout, 32'h0);
        chk("mid_reset_stall", id_stall, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 32'h204, rtype(5'd6, 5'd2, 5'd1, 6'h20), 1'b0, 5'd0, 32'h0, 1'b0);

        // narrow instance: sign extension at DW=16, illegal opcode, index truncation
        s_valid = 1'b1;
        s_npc = 16'h0042;
        s_instr = {6'h3F, 5'd11, 5'd10, 16'h8001};
        s_rw = 1'b1;
        s_rd = 3'd3;
        s_wd = 16'hBEEF;
        @(posedge clk);
        #1;
        s_rw = 1'b0;
        chk("s_sext", s_sx, 16'h8001);
        chk("s_illegal", s_ill, 1'b1);
        chk("s_ctl", {s_wb, s_m, s_ex}, 9'b0);
        chk("s_valid", s_exv, 1'b1);
        chk("s_rs_trunc", s_rs, 3'd3);
        chk("s_bypass", s_a, 16'hBEEF);
        chk("s_npc", s_add, 16'h0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
